// File: rtl/cg_axi5lite_regfile.sv
// cg_axi5lite_regfile: AXI5-Lite subordinate exposing NUM_REGS word registers.
//
// Optional feature macro: CG_AXI5LITE_REGFILE_PRIV_WRITE_EN
//   When defined, a committed write whose AWPROT[0] is 0 (unprivileged) still
//   produces a B response but modifies no register. Reads ignore ARPROT.
//
// Ports:
//   ACLK, ARESETn          clock (rising edge) and async active-low reset
//   AW*  (VALID/READY/ADDR/PROT)   write address channel
//   W*   (VALID/READY/DATA/STRB)   write data channel
//   B*   (VALID/READY)             write response channel
//   AR*  (VALID/READY/ADDR/PROT)   read address channel
//   R*   (VALID/READY/DATA)        read data channel
//   regs_o                 flattened register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
module cg_axi5lite_regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           WVALID,
  output logic                           WREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS_W = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned WORD_W = ADDR_WIDTH - OFFS_W;

  logic                  en;
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  bvalid_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [WORD_W-1:0]     wr_word;
  logic [WORD_W-1:0]     rd_word;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_allow;
  logic                  unused;

  // Readies come from registered state only; en keeps them low through reset.
  assign AWREADY = en & ~aw_held & ~bvalid_q;
  assign WREADY  = en & ~w_held & ~bvalid_q;
  assign ARREADY = en & ~rvalid_q;
  assign BVALID  = bvalid_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign ar_hs = ARVALID & ARREADY;

  // Commit as soon as both halves are available, held or arriving this cycle.
  assign commit = (aw_held | aw_hs) & (w_held | w_hs) & ~bvalid_q;

  assign wr_addr = aw_held ? aw_addr_q : AWADDR;
  assign wr_data = w_held ? w_data_q : WDATA;
  assign wr_strb = w_held ? w_strb_q : WSTRB;

  // Decode over the full address so aliases above NUM_REGS are out of range.
  assign wr_word     = wr_addr[ADDR_WIDTH-1:OFFS_W];
  assign rd_word     = ARADDR[ADDR_WIDTH-1:OFFS_W];
  assign wr_in_range = wr_word < WORD_W'(NUM_REGS);
  assign rd_in_range = rd_word < WORD_W'(NUM_REGS);

`ifdef CG_AXI5LITE_REGFILE_PRIV_WRITE_EN
  logic aw_priv_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_priv_q <= 1'b0;
    end else if (aw_hs && !commit) begin
      aw_priv_q <= AWPROT[0];
    end
  end

  assign wr_allow = aw_held ? aw_priv_q : AWPROT[0];
  assign unused   = ^{AWPROT[2:1], ARPROT, wr_addr[OFFS_W-1:0], ARADDR[OFFS_W-1:0]};
`else
  assign wr_allow = 1'b1;
  assign unused   = ^{AWPROT, ARPROT, wr_addr[OFFS_W-1:0], ARADDR[OFFS_W-1:0]};
`endif

  // Ready enable: rises on the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      en <= 1'b0;
    end else begin
      en <= 1'b1;
    end
  end

  // Write path: holding registers, commit, register update and B response.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (bvalid_q && BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        if (wr_in_range && wr_allow) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) begin
              regs[wr_word[IDX_W-1:0]][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
          end
        end
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= AWADDR;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= WDATA;
          w_strb_q <= WSTRB;
        end
      end
    end
  end

  // Read path: nonblocking register update means same-edge reads see the old value.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_in_range ? regs[rd_word[IDX_W-1:0]] : '0;
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_cg_axi5lite_regfile.sv
// Self-checking bench for cg_axi5lite_regfile (DATA_WIDTH=32, NUM_REGS=16).
// Reference model: a plain array of words updated byte-wise on each write.
module tb_cg_axi5lite_regfile;

  logic         ACLK;
  logic         ARESETn;
  logic         AWVALID;
  logic         AWREADY;
  logic [31:0]  AWADDR;
  logic [2:0]   AWPROT;
  logic         WVALID;
  logic         WREADY;
  logic [31:0]  WDATA;
  logic [3:0]   WSTRB;
  logic         BVALID;
  logic         BREADY;
  logic         ARVALID;
  logic         ARREADY;
  logic [31:0]  ARADDR;
  logic [2:0]   ARPROT;
  logic         RVALID;
  logic         RREADY;
  logic [31:0]  RDATA;
  logic [511:0] regs_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m [16];

  cg_axi5lite_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA),
    .regs_o(regs_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkv(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] flat();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = m[i];
    return f;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] idx;
    idx = a / 4;
    if (idx < 16) return m[idx[3:0]];
    return 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [2:0] p);
    logic [31:0] idx;
    bit allow;
    idx = a / 4;
`ifdef CG_AXI5LITE_REGFILE_PRIV_WRITE_EN
    allow = p[0];
`else
    allow = 1'b1 | p[0];
`endif
    if (idx < 16 && allow) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m[idx[3:0]][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = 32'h0;
  endtask

  // One write; gap = cycles between the two channel handshakes, w_first picks order.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [2:0] p, input int gap, input bit w_first);
    check1("aw_ready_idle", AWREADY, 1'b1);
    check1("w_ready_idle", WREADY, 1'b1);
    AWADDR = a; AWPROT = p; WDATA = d; WSTRB = s;
    if (gap == 0) begin
      AWVALID = 1'b1; WVALID = 1'b1;
      step();
      AWVALID = 1'b0; WVALID = 1'b0;
    end else begin
      if (w_first) WVALID = 1'b1; else AWVALID = 1'b1;
      step();
      AWVALID = 1'b0; WVALID = 1'b0;
      for (int k = 0; k < gap; k++) begin
        check1("held_ready_low", w_first ? WREADY : AWREADY, 1'b0);
        check1("partner_ready_high", w_first ? AWREADY : WREADY, 1'b1);
        check1("no_early_bvalid", BVALID, 1'b0);
        checkv("regs_before_commit", regs_o, flat());
        if (k < gap - 1) step();
      end
      if (w_first) AWVALID = 1'b1; else WVALID = 1'b1;
      step();
      AWVALID = 1'b0; WVALID = 1'b0;
    end
    model_write(a, d, s, p);
    check1("bvalid_after_commit", BVALID, 1'b1);
    check1("aw_ready_during_b", AWREADY, 1'b0);
    checkv("regs_after_write", regs_o, flat());
    step();
    check1("bvalid_cleared", BVALID, 1'b0);
    check1("aw_ready_after_b", AWREADY, 1'b1);
    check1("w_ready_after_b", WREADY, 1'b1);
  endtask

  // One read with RREADY held low for 'hold' extra cycles.
  task automatic rd(input logic [31:0] a, input int hold);
    logic [31:0] exp;
    exp = model_read(a);
    check1("ar_ready_idle", ARREADY, 1'b1);
    ARVALID = 1'b1; ARADDR = a; ARPROT = 3'($urandom_range(0, 7)); RREADY = 1'b0;
    step();
    ARVALID = 1'b0;
    check1("rvalid", RVALID, 1'b1);
    check32("rdata", RDATA, exp);
    for (int k = 0; k < hold; k++) begin
      step();
      check1("rvalid_hold", RVALID, 1'b1);
      check32("rdata_hold", RDATA, exp);
      check1("ar_ready_hold", ARREADY, 1'b0);
    end
    RREADY = 1'b1;
    step();
    check1("rvalid_cleared", RVALID, 1'b0);
    check1("ar_ready_back", ARREADY, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_awready"}, AWREADY, 1'b0);
    check1({tag, "_wready"}, WREADY, 1'b0);
    check1({tag, "_arready"}, ARREADY, 1'b0);
    check1({tag, "_bvalid"}, BVALID, 1'b0);
    check1({tag, "_rvalid"}, RVALID, 1'b0);
    check32({tag, "_rdata"}, RDATA, 32'h0);
    checkv({tag, "_regs"}, regs_o, 512'h0);
  endtask

  initial begin
    logic [31:0] old3;
    logic [31:0] ra;
    ARESETn = 1'b0;
    AWVALID = 1'b0; AWADDR = '0; AWPROT = '0;
    WVALID = 1'b0; WDATA = '0; WSTRB = '0;
    BREADY = 1'b1; ARVALID = 1'b0; ARADDR = '0; ARPROT = '0; RREADY = 1'b1;
    model_reset();

    // Reset state and first ready cycle
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    step();
    check1("first_awready", AWREADY, 1'b1);
    check1("first_wready", WREADY, 1'b1);
    check1("first_arready", ARREADY, 1'b1);

    // AW+W together, then read back
    wr(32'h8, 32'hDEADBEEF, 4'hF, 3'b001, 0, 1'b0);
    rd(32'h8, 0);

    // AW first, W three cycles later
    wr(32'h4, 32'hCAFE0001, 4'hF, 3'b001, 3, 1'b0);
    check32("reg1_value", regs_o[63:32], 32'hCAFE0001);

    // Byte strobes
    wr(32'h8, 32'h11223344, 4'hF, 3'b001, 0, 1'b0);
    wr(32'h8, 32'hAABBCCDD, 4'h5, 3'b001, 0, 1'b0);
    check32("reg2_strobe_merge", regs_o[95:64], 32'h11BB33DD);

    // Out of range write and read
    wr(32'h40, 32'h12345678, 4'hF, 3'b001, 0, 1'b0);
    rd(32'h40, 0);

    // Read back-pressure
    rd(32'h4, 4);

    // W before AW, and a zero-strobe write
    wr(32'hC, 32'h0BADF00D, 4'hF, 3'b001, 2, 1'b1);
    wr(32'hC, 32'hFFFFFFFF, 4'h0, 3'b001, 1, 1'b0);
    check32("reg3_zero_strobe", regs_o[127:96], 32'h0BADF00D);

    // Read and write to the same register on the same edge
    old3 = m[3];
    AWADDR = 32'hC; AWPROT = 3'b001; WDATA = 32'h55AA55AA; WSTRB = 4'hF;
    ARADDR = 32'hC; AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1; RREADY = 1'b1;
    step();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    model_write(32'hC, 32'h55AA55AA, 4'hF, 3'b001);
    check32("same_edge_old_value", RDATA, old3);
    check1("same_edge_bvalid", BVALID, 1'b1);
    checkv("same_edge_regs", regs_o, flat());
    step();
    check1("same_edge_done", RVALID | BVALID, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      ra = 32'($urandom_range(0, 19)) * 4 + 32'($urandom_range(0, 3));
      wr(ra, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
         int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      ra = 32'($urandom_range(0, 19)) * 4 + 32'($urandom_range(0, 3));
      rd(ra, int'($urandom_range(0, 2)));
    end

    // Reset while a B response is pending
    BREADY = 1'b0;
    AWADDR = 32'h14; AWPROT = 3'b001; WDATA = 32'h77777777; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    step();
    AWVALID = 1'b0; WVALID = 1'b0;
    check1("pending_bvalid", BVALID, 1'b1);
    #2;
    ARESETn = 1'b0;
    #1;
    model_reset();
    check_all_zero("midreset");
    step();
    ARESETn = 1'b1;
    BREADY = 1'b1;
    step();
    check1("post_reset_awready", AWREADY, 1'b1);
    check1("post_reset_wready", WREADY, 1'b1);
    check1("post_reset_arready", ARREADY, 1'b1);
    check1("post_reset_bvalid", BVALID, 1'b0);
    checkv("post_reset_regs", regs_o, flat());

`ifdef CG_AXI5LITE_REGFILE_PRIV_WRITE_EN
    // Unprivileged write is dropped but still acknowledged
    wr(32'h0, 32'h5, 4'hF, 3'b000, 0, 1'b0);
    check32("unpriv_reg0", regs_o[31:0], 32'h0);
    wr(32'h0, 32'h5, 4'hF, 3'b001, 0, 1'b0);
    check32("priv_reg0", regs_o[31:0], 32'h5);
`else
    // AWPROT has no effect in the default build
    wr(32'h0, 32'h5, 4'hF, 3'b000, 0, 1'b0);
    check32("prot_ignored_reg0", regs_o[31:0], 32'h5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
